// File: rtl/dmem_access_pkg.sv
// dmem_access_pkg: shared encodings, FSM states and default memory window for the load/store unit
package dmem_access_pkg;
    localparam logic [1:0] S_SW  = 2'b00;
    localparam logic [1:0] S_SH  = 2'b01;
    localparam logic [1:0] S_SB  = 2'b10;
    localparam logic [1:0] S_RSV = 2'b11;
    localparam logic [2:0] L_LW  = 3'b000;
    localparam logic [2:0] L_LH  = 3'b001;
    localparam logic [2:0] L_LHU = 3'b010;
    localparam logic [2:0] L_LB  = 3'b011;
    localparam logic [2:0] L_LBU = 3'b100;
    localparam logic [31:0] DMEM_BASE_DEF  = 32'h10010000;
    localparam int          DMEM_WORDS_DEF = 2048;
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
endpackage

// File: rtl/dmem_lane_mux.sv
// dmem_lane_mux: little-endian lane extraction/extension for loads and lane merge for sub-word stores
module dmem_lane_mux
    import dmem_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_l_mux,
    input  logic [1:0]  i_s_mux,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ldata,
    output logic [31:0] o_mdata
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    assign o_ldata = (i_l_mux == L_LH)  ? {{16{w_half[15]}}, w_half} :
                     (i_l_mux == L_LHU) ? {16'h0, w_half} :
                     (i_l_mux == L_LB)  ? {{24{w_byte[7]}}, w_byte} :
                     (i_l_mux == L_LBU) ? {24'h0, w_byte} : i_rdata;

    // replace only the addressed lane of the old word
    always_comb begin
        o_mdata = i_rdata;
        if (i_s_mux == S_SH)
            o_mdata[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
        else if (i_s_mux == S_SB)
            o_mdata[{i_off, 3'b000} +: 8] = i_wdata[7:0];
    end
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: CPU load/store unit with read-modify-write sub-word stores; DMEM_MISALIGN_TRAP_EN turns misalignment into an error instead of forced alignment
module dmem_access_unit
    import dmem_access_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
    parameter int          DMEM_WORDS = DMEM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_s_mux,
    input  logic [2:0]  req_l_mux,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        mem_ena,
    output logic        mem_rena,
    output logic        mem_wena,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [31:0] DMEM_END = DMEM_BASE + 32'(4 * DMEM_WORDS);

    state_t      r_state, w_next;
    logic        r_req_ready, r_we, r_resp_err;
    logic [1:0]  r_s_mux;
    logic [2:0]  r_l_mux;
    logic [31:0] r_addr, r_wdata, r_merged, r_resp_data;
    logic        w_accept, w_word, w_half, w_rsv, w_oow, w_mis, w_err, w_rmw;
    logic [31:0] w_ea, w_ldata, w_mdata;

    assign w_accept = req_valid && r_req_ready && (r_state == IDLE);
    assign w_word   = r_we ? (r_s_mux == S_SW) : (r_l_mux == L_LW);
    assign w_half   = r_we ? (r_s_mux == S_SH) : (r_l_mux == L_LH || r_l_mux == L_LHU);
    assign w_rsv    = r_we ? (r_s_mux == S_RSV) : (r_l_mux > L_LBU);
`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_mis = (w_half && r_addr[0]) || (w_word && r_addr[1:0] != 2'b00);
    assign w_ea  = r_addr;
`else
    assign w_mis = 1'b0;
    assign w_ea  = {r_addr[31:2], w_word ? 2'b00 : w_half ? {r_addr[1], 1'b0} : r_addr[1:0]};
`endif
    assign w_oow = (w_ea < DMEM_BASE) || (w_ea >= DMEM_END);
    assign w_err = w_rsv || w_oow || w_mis;
    assign w_rmw = r_we && !w_word && !w_err;

    dmem_lane_mux u_lane (
        .i_rdata (mem_rdata),
        .i_off   (w_ea[1:0]),
        .i_l_mux (r_l_mux),
        .i_s_mux (r_s_mux),
        .i_wdata (r_wdata),
        .o_ldata (w_ldata),
        .o_mdata (w_mdata)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state: errors skip memory, sub-word stores take the extra write cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? ACCESS : IDLE;
            ACCESS:  w_next = w_rmw ? WRITE : RESP;
            WRITE:   w_next = RESP;
            RESP:    w_next = resp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // memory strobes only in ACCESS (when legal) and WRITE
    always_comb begin
        mem_ena   = 1'b0;
        mem_rena  = 1'b0;
        mem_wena  = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (r_state == ACCESS && !w_err) begin
            mem_ena   = 1'b1;
            mem_rena  = !(r_we && w_word);
            mem_wena  = r_we && w_word;
            mem_addr  = {w_ea[31:2], 2'b00};
            mem_wdata = (r_we && w_word) ? r_wdata : 32'h0;
        end else if (r_state == WRITE) begin
            mem_ena   = 1'b1;
            mem_wena  = 1'b1;
            mem_addr  = {w_ea[31:2], 2'b00};
            mem_wdata = r_merged;
        end
    end

    // request latch, response registers and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready <= 1'b0;
            r_we        <= 1'b0;
            r_s_mux     <= 2'b00;
            r_l_mux     <= 3'b000;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_merged    <= 32'h0;
            r_resp_data <= 32'h0;
            r_resp_err  <= 1'b0;
        end else begin
            r_req_ready <= (w_next == IDLE);
            if (w_accept) begin
                r_we        <= req_we;
                r_s_mux     <= req_s_mux;
                r_l_mux     <= req_l_mux;
                r_addr      <= req_addr;
                r_wdata     <= req_wdata;
                r_resp_data <= 32'h0;
                r_resp_err  <= 1'b0;
            end
            if (r_state == ACCESS) begin
                r_resp_err  <= w_err;
                r_resp_data <= (!w_err && !r_we) ? w_ldata : 32'h0;
                r_merged    <= w_mdata;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = (r_state == RESP);
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed plus randomized checks of dmem_access_unit against a byte-lane reference model
module tb_dmem_access_unit;
    localparam logic [31:0] BASE = 32'h10010000;
    localparam logic [31:0] SPAN = 32'd8192;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [1:0]  req_s_mux = 2'b00;
    logic [2:0]  req_l_mux = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err, mem_ena, mem_rena, mem_wena;
    logic [31:0] resp_data, mem_addr, mem_wdata, mem_rdata;

    int passes = 0, fails = 0, total = 0;
    logic [31:0] mem [0:2047];
    logic [31:0] ref_mem [0:2047];
    logic        mem_hit;
    logic [10:0] mem_idx;
    logic [31:0] got;

    always #5 clk = ~clk;

    dmem_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_s_mux(req_s_mux), .req_l_mux(req_l_mux), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .mem_ena(mem_ena), .mem_rena(mem_rena), .mem_wena(mem_wena),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_hit   = (mem_addr >= BASE) && (mem_addr < BASE + SPAN);
    assign mem_idx   = 11'((mem_addr - BASE) >> 2);
    assign mem_rdata = mem_hit ? mem[mem_idx] : 32'h0;

    always @(posedge clk) if (mem_ena && mem_wena && mem_hit) mem[mem_idx] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [1:0] s, input logic [2:0] l, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, input string tag, output logic [31:0] data);
        int unsigned nb, off, k, lat, n_ena, n_rena, n_wena, e_lat, e_ena, e_rena, e_wena;
        logic        rsv, mis, oow, e_err;
        logic [31:0] ea, w, v, e_data, e_new, wsnap;
        logic [63:0] m;
        nb  = we ? (s == 2'd0 ? 4 : s == 2'd1 ? 2 : s == 2'd2 ? 1 : 0)
                 : (l == 3'd0 ? 4 : (l == 3'd1 || l == 3'd2) ? 2 : (l == 3'd3 || l == 3'd4) ? 1 : 0);
        rsv = (nb == 0);
        mis = 1'b0;
        ea  = a;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (!rsv) mis = (a % nb) != 0;
`else
        if (!rsv) ea = a - (a % nb);
`endif
        oow    = (ea < BASE) || (ea >= BASE + SPAN);
        e_err  = rsv || mis || oow;
        w      = e_err ? 32'h0 : ref_mem[11'((ea - BASE) >> 2)];
        off    = 8 * (ea % 4);
        m      = (64'd1 << (8 * nb)) - 64'd1;
        v      = (w >> off) & m[31:0];
        if (!we && (l == 3'd1 || l == 3'd3) && nb != 0 && v[8*nb-1]) v = v | ~m[31:0];
        e_data = (e_err || we) ? 32'h0 : v;
        e_new  = (w & ~(m[31:0] << off)) | ((wd & m[31:0]) << off);
        e_lat  = (!e_err && we && nb < 4) ? 3 : 2;
        e_ena  = e_err ? 0 : (we && nb < 4) ? 2 : 1;
        e_wena = (e_err || !we) ? 0 : 1;
        e_rena = e_err ? 0 : (we && nb == 4) ? 0 : 1;
        k = 0;
        while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
        chk({tag, "/ready"}, 32'(req_ready), 32'd1);
        req_we = we; req_s_mux = s; req_l_mux = l; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = $urandom % 2; req_addr = $urandom; req_wdata = $urandom;
        lat = 1; n_ena = 0; n_rena = 0; n_wena = 0; wsnap = 32'h0;
        while (!resp_valid && lat < 8) begin
            chk({tag, "/busy"}, 32'(req_ready), 32'd0);
            if (mem_ena) chk({tag, "/maddr"}, mem_addr, {ea[31:2], 2'b00});
            n_ena += 32'(mem_ena); n_rena += 32'(mem_rena); n_wena += 32'(mem_wena);
            if (mem_wena) wsnap = mem_wdata;
            @(posedge clk); #1; lat++;
        end
        chk({tag, "/lat"}, lat, e_lat);
        chk({tag, "/err"}, 32'(resp_err), 32'(e_err));
        chk({tag, "/data"}, resp_data, e_data);
        chk({tag, "/ena"}, n_ena, e_ena);
        chk({tag, "/rena"}, n_rena, e_rena);
        chk({tag, "/wena"}, n_wena, e_wena);
        if (!e_err && we) chk({tag, "/wdata"}, wsnap, e_new);
        data = resp_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "/hold"}, {resp_data[30:0], resp_valid, req_ready, mem_ena},
                {e_data[30:0], 1'b1, 1'b0, 1'b0});
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, "/done"}, {30'h0, resp_valid, req_ready}, 32'b01);
        if (!e_err && we) ref_mem[11'((ea - BASE) >> 2)] = e_new;
    endtask

    initial begin
        #12;
        chk("rst_outs", {26'h0, req_ready, resp_valid, resp_err, mem_ena, mem_rena, mem_wena}, 32'h0);
        chk("rst_data", resp_data | mem_addr | mem_wdata, 32'h0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rst_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("rst_ready_up", 32'(req_ready), 32'd1);
        for (int i = 0; i < 16; i++) xact(1'b1, 2'b00, 3'b000, BASE + 32'(4 * i), $urandom, 0, "pre", got);

        xact(1'b1, 2'b00, 3'b000, BASE + 32'h4, 32'h11223344, 0, "sw4", got);
        xact(1'b0, 2'b00, 3'b011, BASE + 32'h7, 32'h0, 0, "lb7", got);
        chk("lb7_val", got, 32'h00000011);
        xact(1'b1, 2'b00, 3'b000, BASE + 32'h10, 32'h80FF7F01, 0, "sw10", got);
        xact(1'b0, 2'b00, 3'b001, BASE + 32'h12, 32'h0, 0, "lh12", got);
        chk("lh12_val", got, 32'hFFFF80FF);
        xact(1'b0, 2'b00, 3'b010, BASE + 32'h12, 32'h0, 0, "lhu12", got);
        chk("lhu12_val", got, 32'h000080FF);
        xact(1'b0, 2'b00, 3'b100, BASE + 32'h11, 32'h0, 0, "lbu11", got);
        chk("lbu11_val", got, 32'h0000007F);
        xact(1'b1, 2'b10, 3'b000, BASE + 32'h5, 32'h000000AB, 0, "sb5", got);
        xact(1'b0, 2'b00, 3'b000, BASE + 32'h4, 32'h0, 0, "lw4", got);
        chk("lw4_val", got, 32'h1122AB44);
        xact(1'b1, 2'b00, 3'b000, BASE, 32'hDEADBEEF, 4, "sw_hold", got);
        xact(1'b0, 2'b00, 3'b000, 32'h0FFFFFFC, 32'h0, 0, "lw_low", got);
        xact(1'b1, 2'b11, 3'b000, BASE + 32'h8, 32'h5A5A5A5A, 0, "s_rsv", got);
        xact(1'b0, 2'b00, 3'b101, BASE + 32'h8, 32'h0, 0, "l_rsv", got);
        xact(1'b1, 2'b01, 3'b000, BASE + 32'h1, 32'h00001234, 0, "sh_mis", got);
        xact(1'b0, 2'b00, 3'b000, BASE, 32'h0, 0, "lw_mis", got);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("sh_mis_val", got, 32'hDEADBEEF);
`else
        chk("sh_mis_val", got, 32'hDEAD1234);
`endif
        xact(1'b1, 2'b00, 3'b000, BASE + SPAN - 32'd4, 32'hCAFEF00D, 0, "sw_top", got);
        xact(1'b0, 2'b00, 3'b000, BASE + SPAN - 32'd4, 32'h0, 0, "lw_top", got);
        chk("lw_top_val", got, 32'hCAFEF00D);
        xact(1'b0, 2'b00, 3'b000, BASE + SPAN, 32'h0, 0, "lw_end", got);
        xact(1'b0, 2'b00, 3'b000, BASE - 32'd4, 32'h0, 0, "lw_below", got);

        xact(1'b1, 2'b00, 3'b000, BASE + 32'h8, 32'h55667788, 0, "sw8", got);
        while (!req_ready) begin @(posedge clk); #1; end
        req_we = 1'b1; req_s_mux = 2'b10; req_l_mux = 3'b000; req_addr = BASE + 32'h9; req_wdata = 32'hCC;
        req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_write", {29'h0, mem_ena, mem_wena, mem_rena}, 32'b110);
        rst_n = 1'b0; #1;
        chk("abort_outs", {26'h0, req_ready, resp_valid, resp_err, mem_ena, mem_rena, mem_wena}, 32'h0);
        chk("abort_data", resp_data | mem_addr | mem_wdata, 32'h0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("abort_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("abort_ready_up", 32'(req_ready), 32'd1);
        chk("abort_mem", mem[2], 32'h55667788);
        xact(1'b0, 2'b00, 3'b000, BASE + 32'h8, 32'h0, 0, "lw8", got);
        chk("lw8_val", got, 32'h55667788);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            int unsigned r;
            r = $urandom % 10;
            a = (r == 0) ? BASE + SPAN + ($urandom % 64) : (r == 1) ? 32'h0FFFFFFC : BASE + ($urandom % 64);
            xact(1'($urandom % 2), 2'($urandom % 4), 3'($urandom % 8), a, $urandom, $urandom % 3, "rnd", got);
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
